// File: rtl/csi2_mux_switch_ctrl.sv
// rtl/csi2_mux_switch_ctrl.sv - CSI-2 lane mux select controller, switches only in LP-11 stop state
module csi2_mux_switch_ctrl #(
  parameter int IDLE_CYCLES    = 64,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       req_valid_i,
  input  logic [1:0] req_ch_i,
  output logic       req_ready_o,
  input  logic       lp_dp_i,
  input  logic       lp_dn_i,
  output logic [1:0] mux_sel_o,
  output logic       switch_done_o,
  output logic       timeout_err_o,
  output logic       busy_o
);

  localparam int IDLE_W   = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WAIT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETTLE,
    ST_DONE,
    ST_ABORT
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            tgt_q, tgt_d;
  logic [1:0]            sel_q, sel_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  terr_q, terr_d;
  logic                  busy_q, busy_d;
  logic [SYNC_STAGES-1:0] dp_sync_q, dn_sync_q;
  logic                  lp_ok;

  // Bring the asynchronous LP receiver levels into the clock domain
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dp_sync_q <= '0;
      dn_sync_q <= '0;
    end else begin
      dp_sync_q <= {dp_sync_q[SYNC_STAGES-2:0], lp_dp_i};
      dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], lp_dn_i};
    end
  end

  assign lp_ok = dp_sync_q[SYNC_STAGES-1] & dn_sync_q[SYNC_STAGES-1];

  // Next-state logic; the switch condition is tested before the timeout so it wins a tie
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    sel_d        = sel_q;
    idle_cnt_d   = idle_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          tgt_d = req_ch_i;
          if (req_ch_i == sel_q) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_WAIT;
            idle_cnt_d = '0;
            wait_cnt_d = '0;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = (wait_cnt_q != '1) ? wait_cnt_q + 1'b1 : wait_cnt_q;
        if (lp_ok) begin
          idle_cnt_d = (idle_cnt_q != '1) ? idle_cnt_q + 1'b1 : idle_cnt_q;
        end else begin
          idle_cnt_d = '0;
        end
        if (lp_ok && (idle_cnt_q == IDLE_LAST)) begin
          sel_d        = tgt_q;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ABORT;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_DONE;
        end else begin
          settle_cnt_d = (settle_cnt_q != '1) ? settle_cnt_q + 1'b1 : settle_cnt_q;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so no input reaches an output combinationally
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
    terr_d  = (state_d == ST_ABORT);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      tgt_q        <= '0;
      sel_q        <= '0;
      idle_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      settle_cnt_q <= '0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      terr_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      sel_q        <= sel_d;
      idle_cnt_q   <= idle_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      terr_q       <= terr_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready_o   = ready_q;
  assign mux_sel_o     = sel_q;
  assign switch_done_o = done_q;
  assign timeout_err_o = terr_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_csi2_mux_switch_ctrl.sv
// tb/tb_csi2_mux_switch_ctrl.sv - self-checking bench for csi2_mux_switch_ctrl
module tb_csi2_mux_switch_ctrl;
  localparam int IDLE   = 64;
  localparam int SETTLE = 16;
  localparam int S      = 2;
  localparam int PRE    = 4;
  localparam int TO0    = 500;
  localparam int TO1    = IDLE + 1;
  localparam int MAXN   = 700;

  logic       clk;
  logic       rst_n;
  logic       req_valid [2];
  logic [1:0] req_ch    [2];
  logic       req_ready [2];
  logic       dp        [2];
  logic       dn        [2];
  logic [1:0] mux_sel   [2];
  logic       done      [2];
  logic       terr      [2];
  logic       busy      [2];

  int         checks;
  int         failures;
  logic [1:0] plan      [MAXN];
  logic       obs_rdy   [MAXN];
  logic [1:0] model_sel [2];

  csi2_mux_switch_ctrl #(.IDLE_CYCLES(IDLE), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO0), .SYNC_STAGES(S)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .req_valid_i(req_valid[0]), .req_ch_i(req_ch[0]),
    .req_ready_o(req_ready[0]), .lp_dp_i(dp[0]), .lp_dn_i(dn[0]), .mux_sel_o(mux_sel[0]),
    .switch_done_o(done[0]), .timeout_err_o(terr[0]), .busy_o(busy[0]));

  csi2_mux_switch_ctrl #(.IDLE_CYCLES(IDLE), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO1), .SYNC_STAGES(S)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .req_valid_i(req_valid[1]), .req_ch_i(req_ch[1]),
    .req_ready_o(req_ready[1]), .lp_dp_i(dp[1]), .lp_dn_i(dn[1]), .mux_sel_o(mux_sel[1]),
    .switch_done_o(done[1]), .timeout_err_o(terr[1]), .busy_o(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void fill_plan(input logic [1:0] v);
    for (int j = 0; j < MAXN; j++) plan[j] = v;
  endfunction

  // Reference: the switch happens after the first run of IDLE consecutive LP-11 samples
  // seen inside the waiting window; otherwise the request times out.
  function automatic void predict(input int d, input logic [1:0] ch, input logic [1:0] cur,
                                  output int sw_k, output int done_k, output int to_k);
    int tmo;
    int run;
    tmo = (d == 0) ? TO0 : TO1;
    run = 0;
    sw_k = -1; done_k = -1; to_k = -1;
    if (ch == cur) begin
      done_k = 1;
      return;
    end
    for (int k = 1; k <= tmo; k++) begin
      run = (plan[PRE + k - S] == 2'b11) ? run + 1 : 0;
      if (run == IDLE) begin
        sw_k   = k + 1;
        done_k = k + 1 + SETTLE;
        return;
      end
    end
    to_k = tmo + 1;
  endfunction

  // Plays plan[] on the lane pins, issues a request at cycle T and records what the DUT does
  task automatic run_plan(input int d, input logic [1:0] ch, input int n,
                          input int xk0, input int xk1, input logic [1:0] xch,
                          output int o_sw, output logic [1:0] o_sel, output int o_done,
                          output int n_done, output int o_to, output int n_to, output logic o_busy1);
    logic [1:0] sel0;
    o_sw = -1; o_done = -1; o_to = -1; n_done = 0; n_to = 0; o_busy1 = 1'b0;
    for (int j = 0; j < PRE; j++) begin
      {dp[d], dn[d]} = plan[j];
      @(negedge clk);
    end
    sel0 = mux_sel[d];
    req_valid[d] = 1'b1;
    req_ch[d] = ch;
    {dp[d], dn[d]} = plan[PRE];
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (mux_sel[d] !== sel0 && o_sw < 0) o_sw = k;
      if (done[d] === 1'b1) begin n_done++; if (o_done < 0) o_done = k; end
      if (terr[d] === 1'b1) begin n_to++; if (o_to < 0) o_to = k; end
      if (k == 1) o_busy1 = busy[d];
      obs_rdy[k] = req_ready[d];
      req_valid[d] = (k == xk0 || k == xk1);
      req_ch[d] = (k == xk0 || k == xk1) ? xch : ch;
      {dp[d], dn[d]} = plan[PRE + k];
    end
    {dp[d], dn[d]} = 2'b11;
    o_sel = mux_sel[d];
  endtask

  task automatic test_reset();
    int o_sw, o_done, n_done, o_to, n_to, e_sw, e_done, e_to;
    logic [1:0] o_sel;
    logic o_busy1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready[0]); end
    checks++; if (mux_sel[0] !== 2'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || terr[0] !== 1'b0) begin
      failures++; $display("FAIL reset_outputs sel=%0d busy=%b done=%b terr=%b exp=0/0/0/0", mux_sel[0], busy[0], done[0], terr[0]); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready[0] !== 1'b1 || busy[0] !== 1'b0 || mux_sel[0] !== 2'd0) begin
      failures++; $display("FAIL post_release ready=%b busy=%b sel=%0d exp=1/0/0", req_ready[0], busy[0], mux_sel[0]); end
    fill_plan(2'b11);
    predict(0, 2'd0, model_sel[0], e_sw, e_done, e_to);
    run_plan(0, 2'd0, 6, -1, -1, 2'd0, o_sw, o_sel, o_done, n_done, o_to, n_to, o_busy1);
    checks++; if (o_done !== 1 || o_done !== e_done || n_done !== 1) begin
      failures++; $display("FAIL same_ch_done got=%0d n=%0d exp=1 n=1", o_done, n_done); end
    checks++; if (o_sw !== -1 || o_sel !== 2'd0) begin failures++; $display("FAIL same_ch_sel got=%0d sw=%0d exp=0", o_sel, o_sw); end
    checks++; if (obs_rdy[1] !== 1'b0 || obs_rdy[2] !== 1'b1) begin
      failures++; $display("FAIL same_ch_ready T+1=%b T+2=%b exp=0/1", obs_rdy[1], obs_rdy[2]); end
  endtask

  task automatic test_switch();
    int o_sw, o_done, n_done, o_to, n_to, e_sw, e_done, e_to;
    logic [1:0] o_sel;
    logic o_busy1;
    fill_plan(2'b11);
    predict(0, 2'd2, model_sel[0], e_sw, e_done, e_to);
    run_plan(0, 2'd2, 90, -1, -1, 2'd0, o_sw, o_sel, o_done, n_done, o_to, n_to, o_busy1);
    checks++; if (o_sw !== 65 || o_sw !== e_sw) begin failures++; $display("FAIL switch_time got=%0d exp=65 model=%0d", o_sw, e_sw); end
    checks++; if (o_done !== 81 || o_done !== e_done || n_done !== 1) begin
      failures++; $display("FAIL switch_done got=%0d n=%0d exp=81 model=%0d", o_done, n_done, e_done); end
    checks++; if (obs_rdy[81] !== 1'b0 || obs_rdy[82] !== 1'b1) begin
      failures++; $display("FAIL switch_ready T+81=%b T+82=%b exp=0/1", obs_rdy[81], obs_rdy[82]); end
    checks++; if (o_sel !== 2'd2 || o_busy1 !== 1'b1 || n_to !== 0) begin
      failures++; $display("FAIL switch_state sel=%0d busy=%b to=%0d exp=2/1/0", o_sel, o_busy1, n_to); end
    model_sel[0] = 2'd2;
  endtask

  task automatic test_burst();
    int o_sw, o_done, n_done, o_to, n_to, e_sw, e_done, e_to;
    logic [1:0] o_sel;
    logic o_busy1;
    fill_plan(2'b11);
    for (int j = PRE; j < PRE + 200; j++) plan[j] = 2'($urandom_range(0, 2));
    predict(0, 2'd1, model_sel[0], e_sw, e_done, e_to);
    run_plan(0, 2'd1, 290, -1, -1, 2'd0, o_sw, o_sel, o_done, n_done, o_to, n_to, o_busy1);
    checks++; if (o_sw !== 266 || o_sw !== e_sw) begin failures++; $display("FAIL burst_switch got=%0d exp=266 model=%0d", o_sw, e_sw); end
    checks++; if (o_done !== 282 || o_done !== e_done || o_sel !== 2'd1) begin
      failures++; $display("FAIL burst_done got=%0d sel=%0d exp=282 sel=1", o_done, o_sel); end
    model_sel[0] = 2'd1;
    fill_plan(2'b11);
    for (int j = PRE; j < PRE + 200; j++) plan[j] = 2'b00;
    plan[PRE + 240] = 2'b00;
    predict(0, 2'd0, model_sel[0], e_sw, e_done, e_to);
    run_plan(0, 2'd0, 340, -1, -1, 2'd0, o_sw, o_sel, o_done, n_done, o_to, n_to, o_busy1);
    checks++; if (o_sw !== 307 || o_sw !== e_sw) begin failures++; $display("FAIL glitch_switch got=%0d exp=307 model=%0d", o_sw, e_sw); end
    checks++; if (o_done !== 323 || o_done !== e_done || o_sel !== 2'd0 || n_to !== 0) begin
      failures++; $display("FAIL glitch_done got=%0d sel=%0d to=%0d exp=323 sel=0 to=0", o_done, o_sel, n_to); end
    model_sel[0] = 2'd0;
  endtask

  task automatic test_timeout();
    int o_sw, o_done, n_done, o_to, n_to, e_sw, e_done, e_to;
    logic [1:0] o_sel;
    logic o_busy1;
    fill_plan(2'b11);
    for (int j = PRE; j < MAXN; j++) plan[j] = 2'b00;
    predict(0, 2'd3, model_sel[0], e_sw, e_done, e_to);
    run_plan(0, 2'd3, 520, -1, -1, 2'd0, o_sw, o_sel, o_done, n_done, o_to, n_to, o_busy1);
    checks++; if (o_to !== 501 || o_to !== e_to || n_to !== 1) begin
      failures++; $display("FAIL timeout_pulse got=%0d n=%0d exp=501 model=%0d", o_to, n_to, e_to); end
    checks++; if (n_done !== 0 || o_sw !== -1 || o_sel !== 2'd0) begin
      failures++; $display("FAIL timeout_sel done=%0d sw=%0d sel=%0d exp=0/-1/0", n_done, o_sw, o_sel); end
    checks++; if (obs_rdy[502] !== 1'b1) begin failures++; $display("FAIL timeout_ready got=%b exp=1", obs_rdy[502]); end
  endtask

  task automatic test_ignored();
    int o_sw, o_done, n_done, o_to, n_to, e_sw, e_done, e_to;
    logic [1:0] o_sel;
    logic o_busy1;
    fill_plan(2'b11);
    predict(0, 2'd1, model_sel[0], e_sw, e_done, e_to);
    run_plan(0, 2'd1, 90, 10, 70, 2'd3, o_sw, o_sel, o_done, n_done, o_to, n_to, o_busy1);
    checks++; if (o_sel !== 2'd1 || o_sw !== e_sw) begin failures++; $display("FAIL ignored_sel got=%0d at=%0d exp=1 at=%0d", o_sel, o_sw, e_sw); end
    checks++; if (o_done !== e_done || n_done !== 1) begin
      failures++; $display("FAIL ignored_done got=%0d n=%0d exp=%0d n=1", o_done, n_done, e_done); end
    model_sel[0] = 2'd1;
  endtask

  task automatic test_reset_mid();
    int np;
    fill_plan(2'b11);
    req_ch[0] = 2'd2;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (69) @(negedge clk);
    checks++; if (mux_sel[0] !== 2'd2 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL settle_sel got=%0d busy=%b exp=2/1", mux_sel[0], busy[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mux_sel[0] !== 2'd0 || busy[0] !== 1'b0 || req_ready[0] !== 1'b0 || done[0] !== 1'b0 || terr[0] !== 1'b0) begin
      failures++; $display("FAIL async_reset sel=%0d busy=%b ready=%b done=%b terr=%b exp=0/0/0/0/0",
                           mux_sel[0], busy[0], req_ready[0], done[0], terr[0]); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0] || terr[0] || done[1] || terr[1]) np++;
    end
    checks++; if (np !== 0 || mux_sel[0] !== 2'd0 || req_ready[0] !== 1'b1) begin
      failures++; $display("FAIL reset_discard pulses=%0d sel=%0d ready=%b exp=0/0/1", np, mux_sel[0], req_ready[0]); end
    model_sel[0] = 2'd0;
    model_sel[1] = 2'd0;
  endtask

  task automatic test_tie();
    int o_sw, o_done, n_done, o_to, n_to, e_sw, e_done, e_to;
    logic [1:0] o_sel;
    logic o_busy1;
    fill_plan(2'b11);
    for (int j = 0; j < PRE; j++) plan[j] = 2'b00;
    predict(1, 2'd2, model_sel[1], e_sw, e_done, e_to);
    run_plan(1, 2'd2, 100, -1, -1, 2'd0, o_sw, o_sel, o_done, n_done, o_to, n_to, o_busy1);
    checks++; if (o_sw !== 66 || o_sw !== e_sw || o_sel !== 2'd2) begin
      failures++; $display("FAIL tie_switch got=%0d sel=%0d exp=66 sel=2", o_sw, o_sel); end
    checks++; if (o_done !== 82 || o_done !== e_done || n_to !== 0) begin
      failures++; $display("FAIL tie_done got=%0d to=%0d exp=82 to=0", o_done, n_to); end
    model_sel[1] = 2'd2;
  endtask

  task automatic test_random();
    int o_sw, o_done, n_done, o_to, n_to, e_sw, e_done, e_to, j, len, n;
    logic [1:0] o_sel, ch, v, e_sel;
    logic o_busy1;
    for (int it = 0; it < 8; it++) begin
      j = 0;
      while (j < MAXN) begin
        len = $urandom_range(0, 120);
        v = 2'($urandom_range(0, 2));
        for (int m = 0; m < len && j < MAXN; m++) begin plan[j] = v; j++; end
        len = $urandom_range(1, 100);
        for (int m = 0; m < len && j < MAXN; m++) begin plan[j] = 2'b11; j++; end
      end
      ch = 2'($urandom_range(0, 3));
      predict(0, ch, model_sel[0], e_sw, e_done, e_to);
      n = ((e_done > 0) ? e_done : e_to) + 2;
      e_sel = (e_sw > 0 || e_done == 1) ? ch : model_sel[0];
      run_plan(0, ch, n, -1, -1, 2'd0, o_sw, o_sel, o_done, n_done, o_to, n_to, o_busy1);
      checks++; if (o_sw !== e_sw || o_sel !== e_sel) begin
        failures++; $display("FAIL rand_switch it=%0d got=%0d sel=%0d exp=%0d sel=%0d", it, o_sw, o_sel, e_sw, e_sel); end
      checks++; if (o_done !== e_done || o_to !== e_to || n_done + n_to !== 1) begin
        failures++; $display("FAIL rand_end it=%0d done=%0d to=%0d exp=%0d/%0d", it, o_done, o_to, e_done, e_to); end
      model_sel[0] = e_sel;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_ch[d] = 2'd0;
      dp[d] = 1'b1;
      dn[d] = 1'b1;
      model_sel[d] = 2'd0;
    end
    test_reset();
    test_switch();
    test_burst();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_tie();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csi2_mux_switch_ctrl.md
# csi2_mux_switch_ctrl

Sequential controller that drives the channel-select input of the CSI-2 4-to-1 lane mux. It accepts channel-change requests from the host logic and applies each one only while the currently selected stream is in the LP-11 stop state. This prevents a switch in the middle of a high-speed burst, which would corrupt packets delivered to the downstream CSI-2 receiver. Lane LP state is observed on data lane 0 of the mux output through the single-ended LP receivers.

## Interface
Parameters:
- IDLE_CYCLES, 64: consecutive synchronized LP-11 cycles required before a switch; legal range ≥ 1.
- SETTLE_CYCLES, 16: cycles held after a switch before completion is reported; legal range ≥ 1.
- TIMEOUT_CYCLES, 1048576: maximum cycles spent waiting for idle before the request is aborted; must exceed IDLE_CYCLES.
- SYNC_STAGES, 2: flip-flop depth of the synchronizer on lp_dp_i and lp_dn_i; legal range ≥ 2.

Ports:
- clk_i, input, 1: the single clock for the block.
- reset_n_i, input, 1: reset, asynchronous and active-low.
- req_valid_i, input, 1: channel-change request strobe.
- req_ch_i, input, 2: requested channel, 0–3.
- req_ready_o, output, 1: high when the block can accept a request.
- lp_dp_i, input, 1: LP level of output data lane 0, positive leg; asynchronous to clk_i.
- lp_dn_i, input, 1: LP level of output data lane 0, negative leg; asynchronous to clk_i.
- mux_sel_o, output, 2: channel select driven to the lane mux.
- switch_done_o, output, 1: one-cycle pulse when a request completes.
- timeout_err_o, output, 1: one-cycle pulse when a request is aborted.
- busy_o, output, 1: high in every state except IDLE.

## Operation
- Both LP inputs pass through a SYNC_STAGES-deep synchronizer. lp_ok is high when the synchronized value of {dp, dn} equals 2'b11.
- States:
  - IDLE: req_ready_o=1. When req_valid_i is high, latch req_ch_i into tgt.
    - If tgt equals mux_sel_o, move to DONE.
    - Otherwise move to WAIT and clear idle_cnt and wait_cnt.
  - WAIT: wait_cnt increments every cycle.
    - idle_cnt increments when lp_ok is high and clears to 0 when lp_ok is low.
    - If lp_ok is high and idle_cnt equals IDLE_CYCLES−1: load mux_sel_o with tgt, clear the settle counter, move to SETTLE.
    - Else if wait_cnt equals TIMEOUT_CYCLES−1: move to ABORT.
    - If both conditions hold in the same cycle, the switch wins.
  - SETTLE: counts SETTLE_CYCLES cycles, then moves to DONE. LP activity is ignored in this state.
  - DONE: switch_done_o=1 for one cycle, then IDLE.
  - ABORT: timeout_err_o=1 for one cycle, then IDLE. mux_sel_o keeps its old value.
- req_valid_i is ignored whenever req_ready_o=0. Requests are not queued.
- mux_sel_o changes only on the SETTLE entry edge.
- Counter widths are $clog2 of the parameter value. Counters saturate and never wrap.
- Reset values: mux_sel_o=0, req_ready_o=0 while reset is asserted and 1 from the first clock after release, switch_done_o=0, timeout_err_o=0, busy_o=0, synchronizer flops=2'b00, all counters=0, state=IDLE.
- Reset asserted mid-operation returns the block to IDLE with mux_sel_o=0 immediately (asynchronous). A pending target is discarded and no pulse is emitted.

## Timing
- A request is accepted on cycle T, where req_valid_i & req_ready_o is high.
- Same-channel request: switch_done_o pulses at T+1 and req_ready_o is high again at T+2.
- Different channel with lane already steady at LP-11 (synchronizer settled):
  - mux_sel_o updates at the edge ending cycle T+IDLE_CYCLES, so it is visible in cycle T+IDLE_CYCLES+1.
  - switch_done_o pulses at T+IDLE_CYCLES+1+SETTLE_CYCLES.
- An LP-11 edge at the pins reaches lp_ok after SYNC_STAGES cycles.
- Any single non-LP-11 synchronized sample restarts the full IDLE_CYCLES count.
- Abort: timeout_err_o pulses at cycle T+TIMEOUT_CYCLES+1.
- No combinational path exists from any input to any output.

## Test plan
- Reset, then idle lanes: mux_sel_o=0, busy_o=0, req_ready_o=1 one cycle after reset release. Request ch0 → switch_done_o at T+1, no change to mux_sel_o.
- Lanes held LP-11, request ch2 with IDLE_CYCLES=64 and SETTLE_CYCLES=16 → mux_sel_o=2 visible at T+65, switch_done_o at T+81, req_ready_o high the cycle after.
- HS burst ({dp,dn}=00) for 200 cycles after request ch1, then LP-11 → mux_sel_o stays 0 through the burst. Switch lands 64 cycles after lp_ok rises. One-cycle LP-00 glitch at idle_cnt=40 restarts the count.
- TIMEOUT_CYCLES=500, lanes stuck at 00, request ch3 → timeout_err_o pulse at T+501, mux_sel_o unchanged, no switch_done_o.
- Second req_valid_i pulse during WAIT and SETTLE is ignored, and the original target is applied. Reset asserted during SETTLE → mux_sel_o=0 immediately, no pulses.
- Switch and timeout in the same cycle (TIMEOUT_CYCLES=IDLE_CYCLES+1, LP-11 starting at T+2) → switch taken, switch_done_o asserted, timeout_err_o stays 0.
